// File: rtl/noc_wormhole_arbiter.sv
// Output-port arbiter for a NoC router: round-robin choice among input ports,
// grant held for a whole wormhole packet (first accepted flit through tail).
//
//   state  | meaning
//   IDLE   | no owner; search from rr_ptr, winner granted at next edge
//   LOCKED | one port owns the link until its tail flit transfers
module noc_wormhole_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int FLIT_W  = 64,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_tail,
    input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [FLIT_W-1:0]         out_flit,
    output logic                      out_tail,
    input  logic                      out_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      locked,
    output logic [CNT_W-1:0]          pkt_count
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [PTR_W-1:0]   owner_idx;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     cand;
    logic               found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            pkt_count <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            pkt_count <= cnt_nxt;
        end
    end

    assign locked = (state == LOCKED);

    // grant is one-hot while locked, so a priority encode yields the owner
    always_comb begin
        owner_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) owner_idx = PTR_W'(k);
        end
    end

    // round-robin search: first valid port at or after rr_ptr, wrapping
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = pkt_count;
        req_ready  = '0;
        out_valid  = 1'b0;
        out_flit   = '0;
        out_tail   = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt          = '0;
                    grant_nxt[win_idx] = 1'b1;
                    state_nxt          = LOCKED;
                end
            end
            LOCKED: begin
                out_valid            = req_valid[owner_idx];
                out_flit             = req_flit[owner_idx*FLIT_W +: FLIT_W];
                out_tail             = req_tail[owner_idx];
                req_ready[owner_idx] = out_ready;
                if (out_valid && out_ready && out_tail) begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    rr_ptr_nxt = (owner_idx == PTR_W'(NUM_REQ-1)) ? '0 : owner_idx + 1'b1;
                    cnt_nxt    = pkt_count + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
